fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch stage directly upstream of the instruction register. It owns the program counter and runs a memory read handshake. It captures the returned word and presents it on IRData together with a one-cycle active-low IRLd strobe. That strobe drives the LD input of the downstream load/reset register, which latches the word on the next falling edge. After the strobe it waits for the execute stage to signal completion, then fetches again, either sequentially or from a branch target.

## Interface
- DataWidth, 8: width of instruction word / MemData / IRData
- AddrWidth, 8: width of PC, MemAddr, BranchAddr
- ResetVector, 0: PC value after reset
- Clk  in  1  clock; all state updates on the falling edge
- Reset  in  1  reset, synchronous, active-low
- Stall  in  1  active-low; freezes all state and registered outputs
- MemAck  in  1  active-low; MemData valid this cycle
- MemData  in  DataWidth  instruction word from memory
- Done  in  1  active-low; execute stage finished current instruction
- Branch  in  1  active-low; qualifies Done, take BranchAddr
- BranchAddr  in  AddrWidth  branch target
- MemRd  out  1  active-low read request, registered
- MemAddr  out  AddrWidth  fetch address, registered
- IRData  out  DataWidth  captured instruction, registered
- IRLd  out  1  active-low load strobe to instruction register, registered
- PC  out  AddrWidth  address of the next fetch

## Operation
- States: IDLE, REQ, LOAD, EXEC.
- Reset low at an edge: state IDLE, PC=ResetVector, MemAddr=ResetVector, MemRd=1, IRLd=1, IRData=0. Reset overrides Stall and every other input, in any state.
- IDLE: unconditionally go to REQ next edge; MemRd<=0, MemAddr<=PC.
- REQ: hold MemRd=0 and MemAddr until MemAck is sampled low. On that edge: IRData<=MemData, MemRd<=1, PC<=PC+1 (mod 2^AddrWidth, so all-ones wraps to 0), IRLd<=0, go LOAD.
- LOAD: lasts exactly one cycle. IRLd<=1, go EXEC.
- EXEC: wait for Done sampled low.
  - Done=0, Branch=1: MemAddr<=PC, MemRd<=0, go REQ.
  - Done=0, Branch=0: PC<=BranchAddr, MemAddr<=BranchAddr, MemRd<=0, go REQ. PC increments past BranchAddr on the following fetch.
- Branch is ignored unless Done=0 in the same cycle.
- Done is ignored outside EXEC.
- MemAck is ignored outside REQ.
- Stall=0 at an edge: no state, PC or output change; IRLd held (a strobe stretched by Stall stays low). When Stall returns high, sequencing resumes from the held state.
- Reset mid-REQ: the request is dropped (MemRd=1 next cycle) and PC does not increment. A late MemAck is ignored until the next REQ.

## Timing
- Edges counted as falling edges after Reset released (edge 1 = first with Reset=1).
- With MemAck tied low:
  - edge 1: MemRd falls.
  - edge 2: IRData valid, IRLd falls.
  - edge 3: IRLd rises; the downstream register captures IRData on this edge.
- Fetch latency from entering REQ: 1 + N cycles, where N = cycles MemAck is held off.
- Done sampled low in EXEC at edge k: MemRd=0 and new MemAddr from edge k; earliest next IRLd at edge k+1.
- Steady-state throughput with zero-wait memory and Done returned immediately: one instruction per 3 cycles.
- IRData is stable from its IRLd falling edge until the next REQ-capture edge.
- IRLd is never low for more than one cycle unless Stall=0.

## Test plan
- Reset and first fetch: ResetVector=8'h10, MemAck=0, MemData=8'hA5. Required: MemRd low after edge 1 with MemAddr=10; IRData=A5 and IRLd=0 after edge 2; IRLd=1, PC=11 and state EXEC after edge 3.
- Wait states: MemAck held high 3 cycles in REQ. Required: MemRd stays 0 and MemAddr stable throughout; capture occurs on the first MemAck=0 edge; PC increments exactly once.
- Branch: in EXEC with PC=11, Done=0, Branch=0, BranchAddr=8'h40. Required: MemAddr=40; after the fetch completes, PC=41. Repeat with Branch=0 but Done=1: no effect.
- Wrap: PC=8'hFF. Required: fetch from FF, then PC=00 and the next MemAddr=00.
- Stall: Stall=0 asserted during the LOAD cycle for 2 cycles. Required: IRLd stays 0 for 3 cycles total and no other output changes; normal sequencing resumes after Stall returns high.
- Reset mid-REQ: Reset=0 while MemRd=0. Required: MemRd=1, PC=ResetVector, IRLd=1, IRData=0 on the next edge; a MemAck pulse during reset is ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs an active-low memory read
// handshake and hands each fetched word to the instruction register with a one-cycle IRLd strobe.
module fetch_sequencer #(
  parameter int                   DataWidth   = 8,
  parameter int                   AddrWidth   = 8,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 MemAck,
  input  logic [DataWidth-1:0] MemData,
  input  logic                 Done,
  input  logic                 Branch,
  input  logic [AddrWidth-1:0] BranchAddr,
  output logic                 MemRd,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [DataWidth-1:0] IRData,
  output logic                 IRLd,
  output logic [AddrWidth-1:0] PC,
  output logic [1:0]           StateDbg
);

  // Handshake: MemRd low is a request held until MemAck is sampled low on a
  // falling edge; that edge captures MemData. All strobes are active-low.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2,
    EXEC = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [AddrWidth-1:0]   pc_q, pc_d;
  logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
  logic                   mem_rd_q, mem_rd_d;
  logic [DataWidth-1:0]   ir_data_q, ir_data_d;
  logic                   ir_ld_q, ir_ld_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    ir_data_d  = ir_data_q;
    ir_ld_d    = ir_ld_q;

    if (!Reset) begin
      state_d    = IDLE;
      pc_d       = ResetVector;
      mem_addr_d = ResetVector;
      mem_rd_d   = 1'b1;
      ir_data_d  = '0;
      ir_ld_d    = 1'b1;
    end else if (Stall) begin
      case (state_q)
        IDLE: begin
          state_d    = REQ;
          mem_rd_d   = 1'b0;
          mem_addr_d = pc_q;
        end
        REQ: begin
          if (!MemAck) begin
            state_d   = LOAD;
            ir_data_d = MemData;
            mem_rd_d  = 1'b1;
            pc_d      = pc_q + AddrWidth'(1);
            ir_ld_d   = 1'b0;
          end
        end
        LOAD: begin
          state_d = EXEC;
          ir_ld_d = 1'b1;
        end
        EXEC: begin
          // Branch only means something when it qualifies Done.
          if (!Done) begin
            state_d  = REQ;
            mem_rd_d = 1'b0;
            if (!Branch) begin
              pc_d       = BranchAddr;
              mem_addr_d = BranchAddr;
            end else begin
              mem_addr_d = pc_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge Clk) begin
    state_q    <= state_d;
    pc_q       <= pc_d;
    mem_addr_q <= mem_addr_d;
    mem_rd_q   <= mem_rd_d;
    ir_data_q  <= ir_data_d;
    ir_ld_q    <= ir_ld_d;
  end

  assign MemRd    = mem_rd_q;
  assign MemAddr  = mem_addr_q;
  assign IRData   = ir_data_q;
  assign IRLd     = ir_ld_q;
  assign PC       = pc_q;
  assign StateDbg = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table followed by randomized
// stimulus checked against a behavioural model of the fetch protocol.
module tb_fetch_sequencer;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam logic [AW-1:0] RV = 8'h10;

  logic          Clk;
  logic          Reset;
  logic          Stall;
  logic          MemAck;
  logic [DW-1:0] MemData;
  logic          Done;
  logic          Branch;
  logic [AW-1:0] BranchAddr;
  logic          MemRd;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] IRData;
  logic          IRLd;
  logic [AW-1:0] PC;
  logic [1:0]    StateDbg;

  int tests_run;
  int tests_failed;

  fetch_sequencer #(
    .DataWidth  (DW),
    .AddrWidth  (AW),
    .ResetVector(RV)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Stall     (Stall),
    .MemAck    (MemAck),
    .MemData   (MemData),
    .Done      (Done),
    .Branch    (Branch),
    .BranchAddr(BranchAddr),
    .MemRd     (MemRd),
    .MemAddr   (MemAddr),
    .IRData    (IRData),
    .IRLd      (IRLd),
    .PC        (PC),
    .StateDbg  (StateDbg)
  );

  // Clock: the design acts on the falling edge.
  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  // Behavioural model: the phase is inferred from the observable handshake
  // (request outstanding, strobe pending, fetched-and-executing).
  logic          m_idle;
  logic [AW-1:0] m_pc, m_addr;
  logic          m_rd, m_ld;
  logic [DW-1:0] m_ir;

  function automatic int model_state();
    if (m_idle) return 0;
    if (!m_rd) return 1;
    if (!m_ld) return 2;
    return 3;
  endfunction

  task automatic model_step();
    if (!Reset) begin
      m_idle = 1'b1; m_pc = RV; m_addr = RV;
      m_rd = 1'b1; m_ld = 1'b1; m_ir = '0;
    end else if (!Stall) begin
      // frozen
    end else if (m_idle) begin
      m_idle = 1'b0; m_rd = 1'b0; m_addr = m_pc;
    end else if (!m_rd) begin
      if (!MemAck) begin
        m_ir = MemData; m_rd = 1'b1; m_ld = 1'b0;
        m_pc = AW'((int'(m_pc) + 1) % 256);
      end
    end else if (!m_ld) begin
      m_ld = 1'b1;
    end else if (!Done) begin
      if (!Branch) m_pc = BranchAddr;
      m_addr = m_pc;
      m_rd = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply current inputs at the next falling edge, then let outputs settle.
  task automatic step();
    @(negedge Clk);
    #1;
    model_step();
  endtask

  typedef struct {
    int rst, stl, ack, data, done, br, baddr;
    int e_rd, e_addr, e_ir, e_ld, e_pc, e_st;
  } vec_t;

  vec_t vecs[23];

  initial begin
    tests_run = 0;
    tests_failed = 0;
    Reset = 1'b0; Stall = 1'b1; MemAck = 1'b1; MemData = '0;
    Done = 1'b1; Branch = 1'b1; BranchAddr = '0;

    //          rst stl ack data  done br baddr  rd addr  ir    ld pc    st
    vecs[0]  = '{0, 1, 1, 'h00, 1, 1, 'h00,  1, 'h10, 'h00, 1, 'h10, 0};
    vecs[1]  = '{1, 1, 0, 'hA5, 1, 1, 'h00,  0, 'h10, 'h00, 1, 'h10, 1};
    vecs[2]  = '{1, 1, 0, 'hA5, 1, 1, 'h00,  1, 'h10, 'hA5, 0, 'h11, 2};
    vecs[3]  = '{1, 1, 0, 'hA5, 1, 1, 'h00,  1, 'h10, 'hA5, 1, 'h11, 3};
    vecs[4]  = '{1, 1, 0, 'hA5, 1, 0, 'h40,  1, 'h10, 'hA5, 1, 'h11, 3};
    vecs[5]  = '{1, 1, 1, 'hA5, 0, 0, 'h40,  0, 'h40, 'hA5, 1, 'h40, 1};
    vecs[6]  = '{1, 1, 0, 'h3C, 1, 1, 'h00,  1, 'h40, 'h3C, 0, 'h41, 2};
    vecs[7]  = '{1, 1, 1, 'h3C, 1, 1, 'h00,  1, 'h40, 'h3C, 1, 'h41, 3};
    vecs[8]  = '{1, 1, 1, 'h00, 0, 1, 'h00,  0, 'h41, 'h3C, 1, 'h41, 1};
    vecs[9]  = '{1, 1, 1, 'h00, 1, 1, 'h00,  0, 'h41, 'h3C, 1, 'h41, 1};
    vecs[10] = '{1, 1, 1, 'h00, 1, 1, 'h00,  0, 'h41, 'h3C, 1, 'h41, 1};
    vecs[11] = '{1, 1, 1, 'h00, 1, 1, 'h00,  0, 'h41, 'h3C, 1, 'h41, 1};
    vecs[12] = '{1, 1, 0, 'h77, 1, 1, 'h00,  1, 'h41, 'h77, 0, 'h42, 2};
    vecs[13] = '{1, 0, 1, 'h00, 0, 0, 'h00,  1, 'h41, 'h77, 0, 'h42, 2};
    vecs[14] = '{1, 0, 1, 'h00, 0, 0, 'h00,  1, 'h41, 'h77, 0, 'h42, 2};
    vecs[15] = '{1, 1, 1, 'h00, 1, 1, 'h00,  1, 'h41, 'h77, 1, 'h42, 3};
    vecs[16] = '{1, 1, 1, 'h00, 0, 0, 'hFF,  0, 'hFF, 'h77, 1, 'hFF, 1};
    vecs[17] = '{1, 1, 0, 'h11, 1, 1, 'h00,  1, 'hFF, 'h11, 0, 'h00, 2};
    vecs[18] = '{1, 1, 1, 'h00, 1, 1, 'h00,  1, 'hFF, 'h11, 1, 'h00, 3};
    vecs[19] = '{1, 1, 1, 'h00, 0, 1, 'h00,  0, 'h00, 'h11, 1, 'h00, 1};
    vecs[20] = '{1, 1, 1, 'h00, 1, 1, 'h00,  0, 'h00, 'h11, 1, 'h00, 1};
    vecs[21] = '{0, 1, 0, 'h00, 1, 1, 'h00,  1, 'h10, 'h00, 1, 'h10, 0};
    vecs[22] = '{1, 1, 1, 'h00, 1, 1, 'h00,  0, 'h10, 'h00, 1, 'h10, 1};

    for (int i = 0; i < 23; i++) begin
      Reset      = vecs[i].rst[0];
      Stall      = vecs[i].stl[0];
      MemAck     = vecs[i].ack[0];
      MemData    = vecs[i].data[7:0];
      Done       = vecs[i].done[0];
      Branch     = vecs[i].br[0];
      BranchAddr = vecs[i].baddr[7:0];
      step();
      chk($sformatf("vec%0d MemRd", i),   int'(MemRd),    vecs[i].e_rd);
      chk($sformatf("vec%0d MemAddr", i), int'(MemAddr),  vecs[i].e_addr);
      chk($sformatf("vec%0d IRData", i),  int'(IRData),   vecs[i].e_ir);
      chk($sformatf("vec%0d IRLd", i),    int'(IRLd),     vecs[i].e_ld);
      chk($sformatf("vec%0d PC", i),      int'(PC),       vecs[i].e_pc);
      chk($sformatf("vec%0d state", i),   int'(StateDbg), vecs[i].e_st);
    end

    // Hand sequence: three back-to-back zero-wait fetches, one per 3 cycles.
    Reset = 1'b0; step();
    Reset = 1'b1; MemAck = 1'b0; Done = 1'b0; Branch = 1'b1; Stall = 1'b1;
    step();
    for (int f = 0; f < 3; f++) begin
      MemData = DW'(8'h20 + f);
      step();
      chk($sformatf("tput%0d IRLd", f), int'(IRLd), 0);
      chk($sformatf("tput%0d IRData", f), int'(IRData), 8'h20 + f);
      chk($sformatf("tput%0d PC", f), int'(PC), int'(RV) + f + 1);
      step();
      step();
      chk($sformatf("tput%0d addr", f), int'(MemAddr), int'(RV) + f + 1);
    end

    // Randomized run against the model.
    Reset = 1'b0; step();
    for (int c = 0; c < 3000; c++) begin
      Reset      = ($urandom_range(0, 49) != 0);
      Stall      = ($urandom_range(0, 4) != 0);
      MemAck     = $urandom_range(0, 1) == 1;
      MemData    = DW'($urandom_range(0, 255));
      Done       = ($urandom_range(0, 2) != 0);
      Branch     = $urandom_range(0, 1) == 1;
      BranchAddr = ($urandom_range(0, 7) == 0) ? 8'hFF : AW'($urandom_range(0, 255));
      step();
      chk("rnd MemRd",   int'(MemRd),    int'(m_rd));
      chk("rnd MemAddr", int'(MemAddr),  int'(m_addr));
      chk("rnd IRData",  int'(IRData),   int'(m_ir));
      chk("rnd IRLd",    int'(IRLd),     int'(m_ld));
      chk("rnd PC",      int'(PC),       int'(m_pc));
      chk("rnd state",   int'(StateDbg), model_state());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
